// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue and its CTRL/ID neighbours.
// Stall bit indices mirror the CTRL stall vector layout.
package inst_fetch_queue_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam int          IFQ_DEPTH = 4;
  localparam int          IFQ_AW    = 2;
  localparam int          STALL_IF  = 0;
  localparam int          STALL_ID  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// DEPTH x 64 storage for the fetch queue: synchronous write, combinational read.
// Contents are intentionally not reset; validity is tracked by the owner's count.
module ifq_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetch queue between fetch and ID: buffers {pc, inst} pairs, requests a stall
// one entry before full, drops everything on flush, and flags dropped pushes.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_inst_i,
  input  logic        if_valid_i,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        stallreq_o,
  output logic        overflow_o
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STALL_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = (AW)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  ifq_entry_t    wr_entry;
  ifq_entry_t    head_entry;
  logic [63:0]   head_raw;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = !empty && id_ready_i && !flush_i;
  assign push  = if_valid_i && !flush_i && (!full || pop);
  assign drop  = if_valid_i && !flush_i && full && !pop;

  assign wr_entry.pc   = if_pc_i;
  assign wr_entry.inst = if_inst_i;
  assign head_entry    = ifq_entry_t'(head_raw);

  ifq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head_raw)
  );

  // pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (drop) begin
        overflow_o <= 1'b1;
      end
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push && !pop) begin
          count <= count + CNT_ONE;
        end else if (pop && !push) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  // head presentation: an empty queue shows a NOP at address zero
  always_comb begin
    id_valid_o = !empty;
    id_pc_o    = ZERO_WORD;
    id_inst_o  = NOP_INST;
    if (!empty) begin
      id_pc_o   = head_entry.pc;
      id_inst_o = head_entry.inst;
    end else begin
      id_pc_o   = ZERO_WORD;
      id_inst_o = NOP_INST;
    end
  end

  // leave one slot free for the pair already in flight while CTRL freezes the PC
  assign stallreq_o = !flush_i && (count >= STALL_CNT);

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Prefetch queue directly downstream of the PC generator and instruction ROM; upstream of the ID stage.
- Each cycle it captures the {pc, inst} pair produced by fetch and presents the oldest entry to ID.
- It decouples ID stalls from fetch and raises a stall request to CTRL before it overflows.
- A branch or flush discards all queued entries.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- if_pc_i  in  32  address of the instruction being fetched (`InstAddrBus).
- if_inst_i  in  32  ROM data for if_pc_i (`InstBus).
- if_valid_i  in  1  fetch delivers a valid pair this cycle (ROM ce high and stall[0] clear).
- flush_i  in  1  branch taken or exception; discard queue contents.
- id_ready_i  in  1  ID consumes the head entry this cycle (stall[2] clear).
- id_pc_o  out  32  head entry PC.
- id_inst_o  out  32  head entry instruction.
- id_valid_o  out  1  head entry valid.
- stallreq_o  out  1  stall request to CTRL (stallreq_from_if).
- overflow_o  out  1  sticky error: a push was dropped.

Behaviour:
- Reset (async, rst==0):
  - wr_ptr=0, rd_ptr=0, count=0, overflow_o=0.
  - Outputs: id_valid_o=0, id_pc_o=`ZeroWord, id_inst_o=`ZeroWord, stallreq_o=0.
  - Reset may assert mid-operation; all entries are lost immediately.
- Storage: DEPTH x 64-bit array, written only on push. Array contents are not reset.
- Push condition: if_valid_i && !flush_i && (count<DEPTH || pop).
- Pop condition: id_valid_o && id_ready_i && !flush_i.
- count width is AW+1. Update rules:
  - push and no pop: count+1.
  - pop and no push: count-1.
  - both or neither: count unchanged.
- Pointers are AW bits and wrap modulo DEPTH with no special case.
- Head outputs are combinational from mem[rd_ptr], gated by count!=0:
  - id_valid_o = (count!=0).
  - When count==0: id_pc_o=`ZeroWord and id_inst_o=`ZeroWord (NOP).
- Latency: a pair pushed at edge N is visible at the ID outputs in the cycle after edge N, if the queue was empty. Fall-through within the same cycle is not supported.
- Full with simultaneous pop: the push is accepted. count stays DEPTH, and head advances.
- Full without pop and if_valid_i=1: the pair is dropped and overflow_o is set to 1. overflow_o is cleared only by reset.
- Empty with id_ready_i=1: no pop, and state is unchanged.
- stallreq_o:
  - Combinational: asserted when count >= DEPTH-1.
  - This leaves one slot for the pair already in flight during the cycle CTRL takes to freeze pc_reg.
  - It is not asserted while flush_i=1.
- flush_i=1 at edge:
  - count=0 and rd_ptr=wr_ptr=0.
  - A simultaneous push or pop is ignored.
  - overflow_o is unaffected.
  - The cycle after the flush, id_valid_o=0.
- No internal state machine beyond the count. The implicit states EMPTY, PARTIAL and FULL are derived from count.

Decomposition:
- defines.v (shared) holds `InstAddrBus, `InstBus, `ZeroWord, `NOP.
- Add new constants to defines.v: `IfqDepth (4) and `IfqAw (2).
- Add stall bit indices for CTRL to defines.v: `StallIf=0 and `StallId=2.
- One sub-module: ifq_mem.
  - DEPTH x 64 register array.
  - Synchronous write port, combinational read port.
  - Holds no control logic; pointers, count and flags stay in inst_fetch_queue.

Test Plan:
- Reset and fill:
  - Stimulus: rst low 3 cycles, then rst high. Push pc 0x0,0x4,0x8 with id_ready_i=0.
  - Required: count=3, stallreq_o=1 after the third push. id_pc_o=0x0 and id_inst_o equals the ROM word at 0x0 throughout.
- Streaming:
  - Stimulus: id_ready_i=1 and if_valid_i=1 for 10 cycles starting at pc 0x0.
  - Required: id_pc_o sequence 0x0,0x4,…,0x20, one cycle behind push. count stays 1. stallreq_o=0.
- Full with simultaneous push and pop:
  - Stimulus: fill to 4, then one cycle with if_valid_i=1 and id_ready_i=1 (pc 0x10).
  - Required: count=4, head 0x4, entry 0x10 at the tail. overflow_o=0.
- Overflow:
  - Stimulus: full, id_ready_i=0, push pc 0x14.
  - Required: 0x14 is never presented and overflow_o=1 is held. After reset, overflow_o=0.
- Flush:
  - Stimulus: count=3, then flush_i=1 together with if_valid_i=1 (pc 0x40) and id_ready_i=1.
  - Required next cycle: id_valid_o=0, id_pc_o=0x00000000, count=0. A push of 0x80 in the next cycle appears as head.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst between clock edges while count=2.
  - Required: id_valid_o=0, id_pc_o=0 and stallreq_o=0 immediately, without waiting for a clock edge.
